band_energy_accum: RTL and testbench
====================================

Name: band_energy_accum

Overview:
Downstream consumer of the squaring (power) stage in the MFCC front end. It sums a stream of 32-bit signed power-bin values into NUM_BANDS contiguous, equal-width bands of BINS_PER_BAND bins each, and emits one scaled band energy per band. Results leave through a valid/ready output with a one-entry holding register. This feeds the log/DCT stages.

Parameters:
NUM_BANDS, 8, number of bands per frame (≥2)
BINS_PER_BAND, 16, power bins summed per band (≥2)
ACC_W, 40, accumulator width in bits, unsigned
SHIFT, 4, right shift applied to the band sum before output
OUT_W, 32, band_out width, unsigned

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pow_in  input  32  signed power-bin value, qualified by pow_valid
pow_valid  input  1  pow_in valid this cycle; no backpressure, always accepted
frame_start  input  1  resynchronise the band/bin counters to start of frame
band_out  output  OUT_W  scaled band energy, unsigned
band_idx  output  $clog2(NUM_BANDS)  band number of band_out
band_valid  output  1  band_out/band_idx valid
band_ready  input  1  consumer accepts when band_valid && band_ready
frame_done  output  1  one-cycle pulse when the last band of a frame is loaded into the output register
overrun  output  1  sticky: a completed band was dropped because the output register was occupied

Behaviour:
- Reset: acc=0, bin_cnt=0, band_cnt=0, band_out=0, band_idx=0, band_valid=0, frame_done=0, overrun=0. Reset mid-frame discards the partial sum and any pending output.
- Sample conditioning:
  - A negative pow_in is clamped to 0.
  - Each accepted sample is zero-extended to ACC_W.
  - Addition saturates at 2^ACC_W-1.
- Accumulate: on pow_valid when bin_cnt < BINS_PER_BAND-1, do acc <= acc+sample and bin_cnt++.
- Band completion (pow_valid && bin_cnt == BINS_PER_BAND-1):
  - sum = sat(acc+sample).
  - res = sum >> SHIFT, saturated to 2^OUT_W-1.
  - Same edge: acc <= 0, bin_cnt <= 0.
  - band_cnt increments, wrapping to 0 after NUM_BANDS-1.
  - Result load is attempted on this edge.
- Result load:
  - The holding register is free if band_valid==0, or band_valid && band_ready this cycle.
  - If free: band_out <= res, band_idx <= completing band_cnt, band_valid <= 1.
  - If not free: the new result is dropped, the old one is retained, and overrun <= 1.
  - Latency: band_valid rises on the edge that accepts the last bin of the band, i.e. visible in the cycle after that bin.
- Output handshake:
  - band_valid && band_ready with no simultaneous load gives band_valid <= 0.
  - band_out and band_idx hold stable while band_valid && !band_ready.
- frame_done: pulses high for one cycle on an edge where band_cnt == NUM_BANDS-1 completes and the load succeeds. If the load is dropped, frame_done does not pulse.
- frame_start:
  - Has priority over normal counting.
  - With pow_valid: acc <= sample, bin_cnt <= 1, band_cnt <= 0; that sample is bin 0 of band 0.
  - If BINS_PER_BAND would be 1 this case is undefined; the parameter minimum (≥2) excludes it.
  - Without pow_valid: acc <= 0, bin_cnt <= 0, band_cnt <= 0.
  - The partial band is discarded silently, with no overrun.
  - A pending output register is unaffected.
- Overflow: the ACC_W accumulator saturates without wrapping. With the defaults, the maximum sum of 16×(2^31-1) fits, so saturation is reachable only with a reduced ACC_W. Output saturation applies after the shift.
- overrun clears only on rst.
- No combinational path from pow_in to any output.

Test Plan:
- Defaults: one frame of 128 samples, all 0x00010000, band_ready=1 -> 8 results, each band_out=65536 (1048576>>4), band_idx 0..7 in order; frame_done pulses once, with band 7; overrun=0.
- Negative clamp: band 0 has alternating 0x00010000 and 0xFFFF0000 (−65536) -> band_out=32768 (8×65536>>4).
- Output saturation, SHIFT=0: 16 samples of 0x7FFFFFFF -> band_out=0xFFFFFFFF. ACC_W=34 with the same stimulus -> accumulator holds 2^34-1, and band_out=0xFFFFFFFF.
- Backpressure:
  - With band_ready=0, complete band 0 then band 1 -> band_out keeps band 0 (idx 0), overrun=1.
  - Then band_ready=1 -> band 0 accepted, band_valid drops.
  - Same-cycle accept+load -> no overrun, new band loaded.
- frame_start after 5 samples into band 2 -> counters reset; the next 16 samples produce band_idx=0. With frame_start plus pow_valid=5 followed by 15 samples of 0 (SHIFT=0) -> band_out=5.
- Assert rst mid-band with band_valid=1 -> all outputs 0 next cycle; the following 16 samples produce band_idx=0.

Source files
------------

// File: rtl/band_energy_if.sv
// band_energy_if: power-bin stream in, scaled band energies out with valid/ready
interface band_energy_if #(parameter int NUM_BANDS = 8, parameter int OUT_W = 32);
  logic [31:0] pow_in;
  logic pow_valid, frame_start, band_valid, band_ready, frame_done, overrun;
  logic [OUT_W-1:0] band_out;
  logic [$clog2(NUM_BANDS)-1:0] band_idx;
  modport master(output pow_in, pow_valid, frame_start, band_ready,
                 input band_out, band_idx, band_valid, frame_done, overrun);
  modport slave(input pow_in, pow_valid, frame_start, band_ready,
                output band_out, band_idx, band_valid, frame_done, overrun);
endinterface

// File: rtl/band_energy_accum.sv
// band_energy_accum: sums clamped power bins into equal-width bands and emits scaled band energies
module band_energy_accum #(
  parameter int NUM_BANDS = 8,
  parameter int BINS_PER_BAND = 16,
  parameter int ACC_W = 40,
  parameter int SHIFT = 4,
  parameter int OUT_W = 32
) (
  input logic clk,
  input logic rst,
  band_energy_if.slave bus
);
  localparam int BCW = $clog2(BINS_PER_BAND);
  localparam int IW = $clog2(NUM_BANDS);
  localparam int WW = ACC_W > OUT_W ? ACC_W : OUT_W;
  logic [ACC_W-1:0] acc, smp, sum, shifted;
  logic [ACC_W:0] raw;
  logic [WW-1:0] wide;
  logic [OUT_W-1:0] res;
  logic [BCW-1:0] bin_cnt;
  logic [IW-1:0] band_cnt;
  logic last, last_band, complete, free;
  always_comb begin
    smp = bus.pow_in[31] ? '0 : ACC_W'(bus.pow_in);
    raw = {1'b0, acc} + {1'b0, smp};
    sum = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
    shifted = sum >> SHIFT;
    wide = WW'(shifted);
    res = wide > WW'({OUT_W{1'b1}}) ? '1 : OUT_W'(wide);
    last = bin_cnt == BCW'(BINS_PER_BAND - 1);
    last_band = band_cnt == IW'(NUM_BANDS - 1);
    complete = bus.pow_valid && !bus.frame_start && last;
    free = !bus.band_valid || bus.band_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      bin_cnt <= '0;
      band_cnt <= '0;
      bus.band_out <= '0;
      bus.band_idx <= '0;
      bus.band_valid <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        acc <= bus.pow_valid ? smp : '0;
        bin_cnt <= bus.pow_valid ? BCW'(1) : '0;
        band_cnt <= '0;
      end else if (bus.pow_valid) begin
        acc <= last ? '0 : sum;
        bin_cnt <= last ? '0 : bin_cnt + BCW'(1);
        if (last) band_cnt <= last_band ? '0 : band_cnt + IW'(1);
      end
      bus.frame_done <= complete && free && last_band;
      // a completed band either takes the free holding register or is lost
      if (complete && free) begin
        bus.band_out <= res;
        bus.band_idx <= band_cnt;
        bus.band_valid <= 1'b1;
      end else if (complete) bus.overrun <= 1'b1;
      else if (bus.band_ready) bus.band_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_band_energy_accum.sv
// tb_band_energy_accum: three configurations driven in lockstep against a queue-based band model
module tb_band_energy_accum;
  logic clk = 1'b0, rst = 1'b1, pv = 1'b0, fs = 1'b0, rdy = 1'b0;
  logic [31:0] pin = '0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  band_energy_if #(.NUM_BANDS(8), .OUT_W(32)) b0 ();
  band_energy_if #(.NUM_BANDS(8), .OUT_W(32)) b1 ();
  band_energy_if #(.NUM_BANDS(8), .OUT_W(32)) b2 ();
  assign {b0.pow_in, b0.pow_valid, b0.frame_start, b0.band_ready} = {pin, pv, fs, rdy};
  assign {b1.pow_in, b1.pow_valid, b1.frame_start, b1.band_ready} = {pin, pv, fs, rdy};
  assign {b2.pow_in, b2.pow_valid, b2.frame_start, b2.band_ready} = {pin, pv, fs, rdy};
  band_energy_accum d0 (.clk(clk), .rst(rst), .bus(b0));
  band_energy_accum #(.SHIFT(0)) d1 (.clk(clk), .rst(rst), .bus(b1));
  band_energy_accum #(.SHIFT(0), .ACC_W(34)) d2 (.clk(clk), .rst(rst), .bus(b2));
  logic [31:0] o_out[3];
  logic [2:0] o_idx[3];
  logic o_valid[3], o_done[3], o_ovr[3];
  assign {o_out[0], o_idx[0], o_valid[0], o_done[0], o_ovr[0]} = {b0.band_out, b0.band_idx, b0.band_valid, b0.frame_done, b0.overrun};
  assign {o_out[1], o_idx[1], o_valid[1], o_done[1], o_ovr[1]} = {b1.band_out, b1.band_idx, b1.band_valid, b1.frame_done, b1.overrun};
  assign {o_out[2], o_idx[2], o_valid[2], o_done[2], o_ovr[2]} = {b2.band_out, b2.band_idx, b2.band_valid, b2.frame_done, b2.overrun};
  // reference: bins of the current band kept in a queue, summed whole when the band is full
  int shf[3] = '{4, 0, 0};
  int aw[3] = '{40, 40, 34};
  longint unsigned q[$];
  int band = 0;
  longint unsigned e_out[3];
  int e_idx[3];
  bit e_valid[3], e_done[3], e_ovr[3];
  function automatic longint unsigned clamp(logic [31:0] v);
    return v[31] ? 0 : longint'(v);
  endfunction
  task automatic model_step();
    longint unsigned tot, cap, r;
    bit complete;
    int idx;
    complete = 0;
    tot = 0;
    idx = 0;
    if (rst) begin
      q.delete();
      band = 0;
      for (int k = 0; k < 3; k++) {e_out[k], e_idx[k], e_valid[k], e_done[k], e_ovr[k]} = '0;
      return;
    end
    if (fs) begin
      q.delete();
      band = 0;
      if (pv) q.push_back(clamp(pin));
    end else if (pv) begin
      q.push_back(clamp(pin));
      if (q.size() == 16) begin
        foreach (q[i]) tot += q[i];
        q.delete();
        idx = band;
        band = (band + 1) % 8;
        complete = 1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      e_done[k] = 0;
      if (complete) begin
        cap = (64'd1 << aw[k]) - 1;
        r = (tot > cap ? cap : tot) >> shf[k];
        if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
        if (!e_valid[k] || rdy) begin
          e_out[k] = r;
          e_idx[k] = idx;
          e_valid[k] = 1;
          e_done[k] = idx == 7;
        end else e_ovr[k] = 1;
      end else if (e_valid[k] && rdy) e_valid[k] = 0;
    end
  endtask
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  task automatic tick(logic r, logic p, logic f, logic [31:0] d, logic rd);
    {rst, pv, fs, pin, rdy} = {r, p, f, d, rd};
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), 64'(o_valid[k]), 64'(e_valid[k]));
      chk($sformatf("out%0d", k), 64'(o_out[k]), e_out[k]);
      chk($sformatf("idx%0d", k), 64'(o_idx[k]), 64'(e_idx[k]));
      chk($sformatf("done%0d", k), 64'(o_done[k]), 64'(e_done[k]));
      chk($sformatf("ovr%0d", k), 64'(o_ovr[k]), 64'(e_ovr[k]));
    end
  endtask
  initial begin
    int n_res, n_done;
    logic [31:0] d;
    repeat (3) tick(1, 0, 0, 0, 0);
    n_res = 0;
    n_done = 0;
    for (int i = 0; i < 128; i++) begin
      tick(0, 1, i == 0, 32'h0001_0000, 1);
      if (o_valid[0]) n_res++;
      if (o_done[0]) n_done++;
      if (i == 15) chk("frame_band0", 64'(o_out[0]), 65536);
    end
    chk("frame_results", n_res, 8);
    chk("frame_done_cnt", n_done, 1);
    chk("frame_last_idx", 64'(o_idx[0]), 7);
    for (int i = 0; i < 16; i++) tick(0, 1, i == 0, i[0] ? 32'hFFFF_0000 : 32'h0001_0000, 1);
    chk("neg_clamp", 64'(o_out[0]), 32768);
    for (int i = 0; i < 16; i++) tick(0, 1, i == 0, 32'h7FFF_FFFF, 1);
    chk("sat_shift4", 64'(o_out[0]), 64'h7FFF_FFFF);
    chk("sat_shift0", 64'(o_out[1]), 64'hFFFF_FFFF);
    chk("sat_acc34", 64'(o_out[2]), 64'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) tick(0, 1, i == 0, 32'h0001_0000 * (i / 16 + 1), 0);
    chk("bp_hold_idx", 64'(o_idx[0]), 0);
    chk("bp_overrun", 64'(o_ovr[0]), 1);
    tick(0, 0, 0, 0, 1);
    chk("bp_drain", 64'(o_valid[0]), 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) tick(0, 1, i == 0, 32'h0000_0100 + i, i == 31);
    chk("bp_swap_idx", 64'(o_idx[0]), 1);
    chk("bp_swap_ovr", 64'(o_ovr[0]), 0);
    for (int i = 0; i < 37; i++) tick(0, 1, i == 0, 32'h0000_1000, 1);
    tick(0, 0, 1, 0, 1);
    for (int i = 0; i < 16; i++) tick(0, 1, 0, 32'h0000_2000, 1);
    chk("fs_idx", 64'(o_idx[0]), 0);
    for (int i = 0; i < 16; i++) tick(0, 1, i == 0, i == 0 ? 32'd5 : 32'd0, 1);
    chk("fs_sample", 64'(o_out[1]), 5);
    for (int i = 0; i < 19; i++) tick(0, 1, i == 0, 32'h0000_3000, 0);
    tick(1, 1, 0, 32'h0000_3000, 0);
    chk("rst_valid", 64'(o_valid[0]), 0);
    chk("rst_out", 64'(o_out[0]), 0);
    for (int i = 0; i < 16; i++) tick(0, 1, 0, 32'h0000_4000, 1);
    chk("rst_idx", 64'(o_idx[0]), 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: d = 32'h7FFF_FFFF;
        1: d = 32'h8000_0000 | $urandom;
        2: d = $urandom_range(0, 32'h0010_0000);
        default: d = $urandom;
      endcase
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, d, $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
